// File: rtl/rst_stage_seq.sv
// Staged reset sequencer: releases NUM_STAGES reset outputs in order 0..N-1 after a
// minimum assert window, with soft-reset restart/abort, busy/done status and a completion count.
module rst_stage_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int MIN_ASSERT  = 4,
  parameter int STAGE_DELAY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            seq_count
);

  localparam int CMAX = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  if (NUM_STAGES < 1 || NUM_STAGES > 32 || MIN_ASSERT < 1 || STAGE_DELAY < 1) begin : g_bad_param
    $fatal(1, "rst_stage_seq: illegal parameters");
  end

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [NUM_STAGES-1:0] stage_n;
  logic                  done_n;
  logic [7:0]            seq_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    stage_n = stage_rst;
    done_n  = 1'b0;
    seq_n   = seq_count;
    if (sw_rst_req) begin
      // a request in any state restarts the whole schedule; held high it stretches ASSERT
      state_n = ASSERT;
      cnt_n   = '0;
      idx_n   = '0;
      stage_n = '1;
    end else begin
      case (state)
        ASSERT: begin
          stage_n = '1;
          if (cnt == CW'(MIN_ASSERT - 1)) begin
            stage_n[0] = 1'b0;
            cnt_n      = '0;
            if (NUM_STAGES == 1) begin
              state_n = RUN;
              done_n  = 1'b1;
              seq_n   = (seq_count == 8'hFF) ? seq_count : seq_count + 8'd1;
            end else begin
              state_n = RELEASE;
              idx_n   = IW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == CW'(STAGE_DELAY - 1)) begin
            stage_n[idx] = 1'b0;
            cnt_n        = '0;
            if (idx == IW'(NUM_STAGES - 1)) begin
              state_n = RUN;
              done_n  = 1'b1;
              seq_n   = (seq_count == 8'hFF) ? seq_count : seq_count + 8'd1;
            end else begin
              idx_n = idx + IW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          stage_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASSERT;
      cnt       <= '0;
      idx       <= '0;
      stage_rst <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
      seq_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      stage_rst <= stage_n;
      busy      <= |stage_n;
      done      <= done_n;
      seq_count <= seq_n;
    end
  end

endmodule

// File: tb/tb_rst_stage_seq.sv
// Directed bench for rst_stage_seq: default-parameter instance driven from a vector table,
// plus a 1/1/1 instance exercising seq_count saturation.
module tb_rst_stage_seq;

  logic       clk = 1'b0;
  logic       rst, sw_rst_req;
  logic [3:0] stage_rst;
  logic       busy, done;
  logic [7:0] seq_count;

  logic       rst1, sw1;
  logic [0:0] stage1;
  logic       busy1, done1;
  logic [7:0] seq1;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rst_stage_seq dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .stage_rst(stage_rst), .busy(busy), .done(done), .seq_count(seq_count)
  );

  rst_stage_seq #(.NUM_STAGES(1), .MIN_ASSERT(1), .STAGE_DELAY(1)) dut1 (
    .clk(clk), .rst(rst1), .sw_rst_req(sw1),
    .stage_rst(stage1), .busy(busy1), .done(done1), .seq_count(seq1)
  );

  typedef struct {
    logic       rst;
    logic       sw;
    int         ncyc;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic [7:0] seq;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cycle monitors on the default instance
  logic       mon_en = 1'b0;
  logic [3:0] prev_stage;
  logic       prev_done, prev_rst, prev_sw;
  int busy_err = 0, done_err = 0, mono_err = 0, done_cnt = 0, done1_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy !== (|stage_rst)) busy_err++;
      if (done && (prev_done || prev_rst)) done_err++;
      if (((stage_rst & ~prev_stage) != 4'b0) && !(prev_rst || prev_sw)) mono_err++;
      if (done) done_cnt++;
    end
    if (done1 === 1'b1) done1_cnt++;
    prev_stage = stage_rst;
    prev_done  = done;
    prev_rst   = rst;
    prev_sw    = sw_rst_req;
  end

  vec_t vt[31];

  initial begin
    int d0;
    rst = 1'b1; sw_rst_req = 1'b0;
    rst1 = 1'b1; sw1 = 1'b0;

    // T1 reset + full sequence
    vt[0]  = '{1, 0, 3, 4'b1111, 1, 0, 0};
    vt[1]  = '{0, 0, 3, 4'b1111, 1, 0, 0};
    vt[2]  = '{0, 0, 1, 4'b1110, 1, 0, 0};
    vt[3]  = '{0, 0, 7, 4'b1110, 1, 0, 0};
    vt[4]  = '{0, 0, 1, 4'b1100, 1, 0, 0};
    vt[5]  = '{0, 0, 8, 4'b1000, 1, 0, 0};
    vt[6]  = '{0, 0, 7, 4'b1000, 1, 0, 0};
    vt[7]  = '{0, 0, 1, 4'b0000, 0, 1, 1};
    vt[8]  = '{0, 0, 1, 4'b0000, 0, 0, 1};
    // T2 single soft request from RUN
    vt[9]  = '{0, 1, 1, 4'b1111, 1, 0, 1};
    vt[10] = '{0, 0, 3, 4'b1111, 1, 0, 1};
    vt[11] = '{0, 0, 1, 4'b1110, 1, 0, 1};
    vt[12] = '{0, 0, 24, 4'b0000, 0, 1, 2};
    vt[13] = '{0, 0, 1, 4'b0000, 0, 0, 2};
    // T3 abort during RELEASE at E0+6
    vt[14] = '{1, 0, 1, 4'b1111, 1, 0, 0};
    vt[15] = '{0, 0, 5, 4'b1110, 1, 0, 0};
    vt[16] = '{0, 1, 1, 4'b1111, 1, 0, 0};
    vt[17] = '{0, 0, 4, 4'b1110, 1, 0, 0};
    vt[18] = '{0, 0, 24, 4'b0000, 0, 1, 1};
    vt[19] = '{0, 0, 1, 4'b0000, 0, 0, 1};
    // T4 hard reset mid-RELEASE
    vt[20] = '{1, 0, 1, 4'b1111, 1, 0, 0};
    vt[21] = '{0, 0, 14, 4'b1100, 1, 0, 0};
    vt[22] = '{1, 0, 1, 4'b1111, 1, 0, 0};
    vt[23] = '{0, 0, 4, 4'b1110, 1, 0, 0};
    vt[24] = '{0, 0, 24, 4'b0000, 0, 1, 1};
    // T5 request held 10 edges
    vt[25] = '{0, 1, 10, 4'b1111, 1, 0, 1};
    vt[26] = '{0, 0, 3, 4'b1111, 1, 0, 1};
    vt[27] = '{0, 0, 1, 4'b1110, 1, 0, 1};
    vt[28] = '{0, 0, 24, 4'b0000, 0, 1, 2};
    // rst and sw together: rst wins, count cleared
    vt[29] = '{1, 1, 1, 4'b1111, 1, 0, 0};
    vt[30] = '{0, 0, 28, 4'b0000, 0, 1, 1};

    for (int i = 0; i < 31; i++) begin
      rst = vt[i].rst; sw_rst_req = vt[i].sw;
      repeat (vt[i].ncyc) step();
      if (i == 0) mon_en = 1'b1;
      check($sformatf("row%0d stage_rst", i), 32'(stage_rst), 32'(vt[i].stage));
      check($sformatf("row%0d busy", i),      32'(busy),      32'(vt[i].busy));
      check($sformatf("row%0d done", i),      32'(done),      32'(vt[i].done));
      check($sformatf("row%0d seq_count", i), 32'(seq_count), 32'(vt[i].seq));
    end
    sw_rst_req = 1'b0;
    step();
    check("done_pulse_total", 32'(done_cnt), 32'd6);
    check("busy_tracks_stage", 32'(busy_err), 32'd0);
    check("done_no_b2b_or_rst", 32'(done_err), 32'd0);
    check("monotonic_release", 32'(mono_err), 32'd0);

    // T6 saturation on the single-stage instance
    rst1 = 1'b0;
    repeat (3) step();
    check("t6 initial seq", 32'(seq1), 32'd1);
    check("t6 initial stage", 32'(stage1), 32'd0);
    d0 = done1_cnt;
    for (int i = 0; i < 260; i++) begin
      sw1 = 1'b1;
      step();
      if (i == 0) check("t6 stage asserted", 32'(stage1), 32'd1);
      sw1 = 1'b0;
      repeat (2) step();
      if (i == 252) check("t6 seq 254", 32'(seq1), 32'd254);
      if (i == 253) check("t6 seq 255", 32'(seq1), 32'd255);
    end
    check("t6 seq saturated", 32'(seq1), 32'd255);
    check("t6 done pulses", 32'(done1_cnt - d0), 32'd260);
    check("t6 busy idle", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
